// File: rtl/gzip_pkg.sv
// Shared GZIP framing definitions: FSM states, RFC 1952 header constants and lengths.
// The HEADER state exists only when GZIP_TRAILER_HEADER_EN is defined.
package gzip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef GZIP_TRAILER_HEADER_EN
    ST_HEADER,
`endif
    ST_PAYLOAD,
    ST_CRC_WAIT,
    ST_TRAILER
  } state_e;

  localparam logic [7:0] ID1        = 8'h1F;
  localparam logic [7:0] ID2        = 8'h8B;
  localparam logic [7:0] CM_DEFLATE = 8'h08;
  localparam logic [7:0] OS_UNKNOWN = 8'hFF;

  localparam int unsigned GZIP_HDR_LEN = 10;
  localparam int unsigned GZIP_TRL_LEN = 8;

  // Fixed member header: FLG, MTIME and XFL are all zero.
  function automatic logic [7:0] gzip_header_byte(input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = ID1;
      4'd1:    b = ID2;
      4'd2:    b = CM_DEFLATE;
      4'd9:    b = OS_UNKNOWN;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/gzip_trailer_gen.sv
// GZIP member framer: passes payload through, counts ISIZE and appends the CRC32/ISIZE trailer.
// Define GZIP_TRAILER_HEADER_EN to prepend the fixed 10-byte member header.
module gzip_trailer_gen
  import gzip_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        crc_init,
  output logic [7:0]  crc_byte,
  output logic        crc_byte_valid,
  input  logic [31:0] crc_in,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready
);

  localparam logic [3:0] TRL_LAST_IDX = 4'(GZIP_TRL_LEN - 1);
`ifdef GZIP_TRAILER_HEADER_EN
  localparam logic [3:0] HDR_LAST_IDX = 4'(GZIP_HDR_LEN - 1);
`endif

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] isize_q, isize_d;
  logic [31:0] crc_q, crc_d;

  logic [63:0] trl_word;
  logic [7:0]  frame_byte;

  // The CRC stage sees every payload byte; crc_byte_valid says which ones count.
  assign crc_byte = s_data;

  // Trailer is CRC32 then ISIZE, both little-endian, so one 64-bit word indexed by byte.
  assign trl_word = {isize_q, crc_q};

  // Single byte mux for the framed (non-payload) bytes, indexed by idx.
  always_comb begin
    frame_byte = trl_word[{idx_q[2:0], 3'b000} +: 8];
`ifdef GZIP_TRAILER_HEADER_EN
    if (state_q == ST_HEADER) frame_byte = gzip_header_byte(idx_q);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      isize_q <= 32'd0;
      crc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      isize_q <= isize_d;
      crc_q   <= crc_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    isize_d        = isize_q;
    crc_d          = crc_q;
    s_ready        = 1'b0;
    m_valid        = 1'b0;
    m_last         = 1'b0;
    m_data         = 8'h00;
    crc_init       = 1'b0;
    crc_byte_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // One bubble per member; the CRC reload happens here, so it never
        // coincides with the first accumulated byte.
        if (s_valid) begin
          crc_init = 1'b1;
          isize_d  = 32'd0;
          idx_d    = 4'd0;
`ifdef GZIP_TRAILER_HEADER_EN
          state_d  = ST_HEADER;
`else
          state_d  = ST_PAYLOAD;
`endif
        end
      end

`ifdef GZIP_TRAILER_HEADER_EN
      ST_HEADER: begin
        m_valid = 1'b1;
        m_data  = frame_byte;
        if (m_ready) begin
          if (idx_q == HDR_LAST_IDX) begin
            idx_d   = 4'd0;
            state_d = ST_PAYLOAD;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
`endif

      ST_PAYLOAD: begin
        s_ready = m_ready;
        m_valid = s_valid;
        m_data  = s_valid ? s_data : 8'h00;
        if (s_valid && m_ready) begin
          crc_byte_valid = 1'b1;
          isize_d        = isize_q + 32'd1;
          if (s_last) state_d = ST_CRC_WAIT;
        end
      end

      ST_CRC_WAIT: begin
        // crc_in is registered in the CRC stage and reflects the last byte only now.
        crc_d   = crc_in;
        idx_d   = 4'd0;
        state_d = ST_TRAILER;
      end

      ST_TRAILER: begin
        m_valid = 1'b1;
        m_data  = frame_byte;
        m_last  = (idx_q == TRL_LAST_IDX);
        if (m_ready) begin
          if (idx_q == TRL_LAST_IDX) begin
            idx_d   = 4'd0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gzip_trailer_gen.sv
// Scoreboard bench for gzip_trailer_gen with a cycle-level CRC-32 stage model.
// Follows GZIP_TRAILER_HEADER_EN to decide whether the header is expected.
module tb_gzip_trailer_gen;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        crc_init;
  logic [7:0]  crc_byte;
  logic        crc_byte_valid;
  logic [31:0] crc_in;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_init = 0;
  bit   throttle = 1'b0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  gzip_trailer_gen dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .crc_init       (crc_init),
    .crc_byte       (crc_byte),
    .crc_byte_valid (crc_byte_valid),
    .crc_in         (crc_in),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_last         (m_last),
    .m_ready        (m_ready)
  );

  // Reflected CRC-32 (poly EDB88320), one byte.
  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  function automatic logic [31:0] crc32_ref(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) c = crc_step(c, b[i]);
    return ~c;
  endfunction

  function automatic bq_t str_bytes(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Upstream CRC stage: registered, output already complemented.
  logic [31:0] crc_reg;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              crc_reg <= 32'hFFFFFFFF;
    else if (crc_init)       crc_reg <= 32'hFFFFFFFF;
    else if (crc_byte_valid) crc_reg <= crc_step(crc_reg, crc_byte);
  end
  assign crc_in = ~crc_reg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected member: optional header, payload, CRC32 LE, ISIZE LE.
  task automatic push_expected(input bq_t b);
    logic [31:0] crc;
    logic [31:0] isize;
    exp_t e;
`ifdef GZIP_TRAILER_HEADER_EN
    bq_t hdr;
    hdr = '{8'h1F, 8'h8B, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    foreach (hdr[i]) begin e.data = hdr[i]; e.last = 1'b0; sb_q.push_back(e); end
`endif
    crc   = crc32_ref(b);
    isize = 32'(b.size());
    foreach (b[i]) begin e.data = b[i]; e.last = 1'b0; sb_q.push_back(e); end
    for (int i = 0; i < 4; i++) begin e.data = crc[8*i +: 8]; e.last = 1'b0; sb_q.push_back(e); end
    for (int i = 0; i < 4; i++) begin e.data = isize[8*i +: 8]; e.last = (i == 3); sb_q.push_back(e); end
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks protocol rules.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'b0, m_valid}, 32'd1);
        check("hold_data", {24'b0, m_data}, {24'b0, prev_data});
      end
      if (!m_valid) check("data_zero_when_invalid", {24'b0, m_data}, 32'd0);
      if (crc_init) begin
        n_init++;
        check("init_vs_accum", {31'b0, crc_byte_valid}, 32'd0);
      end
      if (crc_byte_valid) check("crc_byte", {24'b0, crc_byte}, {24'b0, s_data});
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'(sb_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("m_data", {24'b0, m_data}, {24'b0, e.data});
          check("m_last", {31'b0, m_last}, {31'b0, e.last});
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  always @(posedge clk) begin
    #1;
    m_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Drive one member; returns at posedge+1 after the last byte was accepted.
  task automatic send_member(input bq_t b, input bit hold);
    bit acc;
    int budget;
    push_expected(b);
    foreach (b[i]) begin
      s_valid = 1'b1;
      s_data  = b[i];
      s_last  = (i == b.size() - 1);
      budget  = 500;
      acc     = 1'b0;
      while (!acc && budget > 0) begin
        @(negedge clk);
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
        budget--;
      end
      if (!acc) check("s_ready_timeout", {31'b0, acc}, 32'd1);
    end
    if (!hold) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'h00;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 2000;
    while (sb_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t b;
    int  init_before;
    int  budget;

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;
    #12;
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_m_data", {24'b0, m_data}, 32'd0);
    check("rst_m_last", {31'b0, m_last}, 32'd0);
    check("rst_s_ready", {31'b0, s_ready}, 32'd0);
    check("rst_crc_init", {31'b0, crc_init}, 32'd0);
    check("rst_crc_byte_valid", {31'b0, crc_byte_valid}, 32'd0);
    check("crc_ref_kat", crc32_ref(str_bytes("123456789")), 32'hCBF43926);
    check("crc_ref_a", crc32_ref(str_bytes("a")), 32'hE8B7BE43);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // "123456789", no backpressure.
    send_member(str_bytes("123456789"), 1'b0);
    drain();

    // Single byte "a": CRC_WAIT bubble, then trailer byte 0 two cycles after the last byte.
    send_member(str_bytes("a"), 1'b0);
    @(negedge clk);
    check("crc_wait_m_valid", {31'b0, m_valid}, 32'd0);
    check("crc_wait_s_ready", {31'b0, s_ready}, 32'd0);
    @(negedge clk);
    check("trailer_start_m_valid", {31'b0, m_valid}, 32'd1);
    drain();

    // Throttled downstream.
    throttle = 1'b1;
    send_member(str_bytes("123456789"), 1'b0);
    drain();
    throttle = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of the trailer (index 3).
    send_member(str_bytes("123456789"), 1'b0);
    budget = 500;
    while (sb_q.size() != 5 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check("reach_trailer_idx3", 32'(sb_q.size()), 32'd5);
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", {31'b0, m_valid}, 32'd0);
    check("arst_m_data", {24'b0, m_data}, 32'd0);
    check("arst_m_last", {31'b0, m_last}, 32'd0);
    check("arst_s_ready", {31'b0, s_ready}, 32'd0);
    check("arst_crc_init", {31'b0, crc_init}, 32'd0);
    sb_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_member(str_bytes("a"), 1'b0);
    drain();

    // Back-to-back members with s_valid held high.
    init_before = n_init;
    send_member(str_bytes("a"), 1'b1);
    send_member(str_bytes("123456789"), 1'b0);
    drain();
    check("crc_init_per_member", 32'(n_init - init_before), 32'd2);

    // Randomized members and backpressure.
    throttle    = 1'b1;
    init_before = n_init;
    for (int m = 0; m < 8; m++) begin
      b.delete();
      for (int i = 0; i < $urandom_range(1, 16); i++) b.push_back(8'($urandom()));
      send_member(b, 1'($urandom_range(0, 1)));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    drain();
    check("crc_init_random", 32'(n_init - init_before), 32'd8);
    throttle = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gzip_trailer_gen.md
# gzip_trailer_gen

Byte-stream framing stage placed directly downstream of the CRC-32 byte engine in the GZIP output path. It passes the payload through unchanged and tells the CRC stage which bytes to accumulate. It counts payload bytes (ISIZE). After the last payload byte it appends the 8-byte RFC 1952 trailer: CRC32 then ISIZE, each little-endian. When configured, it also prepends the fixed 10-byte GZIP member header.

## Interface
Parameters:
- none; all widths fixed by RFC 1952.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- s_data  in  8  payload byte.
- s_valid  in  1  payload byte valid.
- s_last  in  1  marks the final payload byte of a member.
- s_ready  out  1  payload byte accepted when s_valid & s_ready.
- crc_init  out  1  one-cycle pulse; CRC stage reloads 32'hFFFFFFFF.
- crc_byte  out  8  byte to accumulate; equals s_data.
- crc_byte_valid  out  1  equals s_valid & s_ready in PAYLOAD.
- crc_in  in  32  final, already-complemented CRC from the CRC stage; registered there, so valid one cycle after a byte is accumulated.
- m_data  out  8  output byte.
- m_valid  out  1  output byte valid.
- m_last  out  1  final trailer byte of the member.
- m_ready  in  1  downstream accepts when m_valid & m_ready.

## Operation
States: IDLE, HEADER (only with macro), PAYLOAD, CRC_WAIT, TRAILER.
- IDLE: s_ready=0, m_valid=0.
  - On s_valid=1: crc_init pulses, isize clears to 0, byte index clears to 0.
  - Next state is HEADER (macro) or PAYLOAD.
- HEADER: m_valid=1, s_ready=0; m_data = header[idx].
  - Header bytes, in order: 1F 8B 08 00 00 00 00 00 00 FF (CM=deflate, FLG=0, MTIME=0, XFL=0, OS=255).
  - idx advances on m_ready; after index 9 is accepted → PAYLOAD, idx=0.
- PAYLOAD: combinational pass-through.
  - m_data=s_data, m_valid=s_valid, s_ready=m_ready, m_last=0.
  - Each accepted byte: isize += 1, modulo 2^32 (wraps FFFFFFFF→0).
  - Accepted byte with s_last=1 → CRC_WAIT.
- CRC_WAIT: one cycle; s_ready=0, m_valid=0.
  - crc_q latches crc_in; isize is frozen → TRAILER, idx=0.
- TRAILER: m_valid=1, s_ready=0.
  - m_data by idx: crc_q[7:0], [15:8], [23:16], [31:24], then isize[7:0], [15:8], [23:16], [31:24].
  - m_last=1 at idx 7. Accepting idx 7 → IDLE.
- Every member carries at least one payload byte. An empty member is not supported; s_last must accompany a real byte.
- m_data is 8'h00 whenever m_valid=0.
- m_valid, once asserted in HEADER or TRAILER, holds with stable m_data until accepted.

## Timing
- Reset values: state=IDLE, s_ready=0, m_valid=0, m_last=0, m_data=0, crc_init=0, crc_byte_valid=0, isize=0, crc_q=0, idx=0.
- Reset is asynchronous at any point, including mid-HEADER or mid-TRAILER. The block returns to IDLE and discards the partial member; no trailer is completed.
- Payload latency is 0 cycles, combinational from s_* to m_* and from m_ready to s_ready.
- IDLE costs 1 bubble cycle per member.
- Last payload byte to first trailer byte: 2 cycles (CRC_WAIT, then TRAILER presents byte 0).
- Minimum member cost: 1 + N + 1 + 8 cycles, plus 10 with the header.
- s_valid asserted while in CRC_WAIT or TRAILER is held off (s_ready=0). The byte is taken after return to IDLE as the start of the next member.
- crc_init and the first crc_byte_valid never coincide; crc_init is in IDLE, accumulation starts the cycle after.

## Configuration
- GZIP_TRAILER_HEADER_EN defined: HEADER state exists and the 10-byte header precedes the payload.
- Undefined: no HEADER state. IDLE goes straight to PAYLOAD and the output is payload + trailer only.

## Structure
- Shared package gzip_pkg holds:
  - state enum;
  - header byte constants (ID1=8'h1F, ID2=8'h8B, CM_DEFLATE=8'h08, OS_UNKNOWN=8'hFF);
  - GZIP_HDR_LEN=10 and GZIP_TRL_LEN=8.
- Single module; no sub-module. Header and trailer selection is one byte mux indexed by idx (4 bits).

## Test plan
- "123456789" (31..39), no backpressure, macro off → payload echoed, then 26 39 F4 CB 09 00 00 00 with m_last on the final byte.
- Single byte "a" (61) with s_last → 61, then 43 BE B7 E8 01 00 00 00; CRC_WAIT cycle shows m_valid=0.
- Random m_ready throttling (50%) on "123456789" → byte stream identical to the first test; m_data stable while m_valid & !m_ready.
- Macro on, "a" → 1F 8B 08 00 00 00 00 00 00 FF 61 43 BE B7 E8 01 00 00 00; s_ready=0 throughout HEADER.
- rst_n pulsed low at TRAILER idx 3 → all outputs 0 immediately. Next member "a" then yields the correct trailer with ISIZE=1.
- Back-to-back members "a" then "123456789", s_valid held high → second member starts after IDLE bubble, crc_init pulses once per member, ISIZE=9.
